spi_i2s_ipi_spi_shifter: RTL and testbench

SPI master shift engine that consumes the bit-rate strobe from spi_i2s_ipi_clk_div. It accepts a parallel word through a valid/ready handshake and frames it with chip-select. It serialises the word on MOSI and deserialises MISO. Each time-base pulse advances exactly one SCK half-period, so the divider setting alone sets the bit rate.

---
 rtl/spi_i2s_ipi_spi_shifter.sv | 168 ++++++++++++++++
 tb/tb_spi_i2s_ipi_spi_shifter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_i2s_ipi_spi_shifter.sv
// spi_i2s_ipi_spi_shifter
// SPI master shift engine paced by the clock-divider strobe. Every strobe
// advances exactly one SCK half-period, so the divider alone sets the bit rate.
// The frame configuration (mode, bit order, length) is captured at the
// handshake and stays frozen until the frame ends or is aborted.
module spi_i2s_ipi_spi_shifter #(
   parameter int PARAM_DATA_WIDTH = 32,
   parameter int PARAM_LEN_WIDTH  = 5
) (
   input  logic                        spis_clk,
   input  logic                        spis_rst_n,
   input  logic                        spis_enable_i,
   input  logic                        spis_time_base_i,
   input  logic                        spis_cpol_i,
   input  logic                        spis_cpha_i,
   input  logic                        spis_lsb_first_i,
   input  logic [PARAM_LEN_WIDTH-1:0]  spis_len_i,
   input  logic [PARAM_DATA_WIDTH-1:0] spis_tx_data_i,
   input  logic                        spis_tx_valid_i,
   output logic                        spis_tx_ready_o,
   output logic [PARAM_DATA_WIDTH-1:0] spis_rx_data_o,
   output logic                        spis_rx_valid_o,
   output logic                        spis_busy_o,
   output logic                        spis_sck_o,
   output logic                        spis_mosi_o,
   input  logic                        spis_miso_i,
   output logic                        spis_cs_n_o
);

   // Edge counter spans 0..2N-1, so it needs one bit more than the length field.
   localparam int CNT_WIDTH = PARAM_LEN_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD
   } state_t;

   state_t                      state;
   logic [PARAM_DATA_WIDTH-1:0] tx_word;
   logic [PARAM_DATA_WIDTH-1:0] rx_word;
   logic                        cpol_q;
   logic                        cpha_q;
   logic                        lsb_q;
   logic [PARAM_LEN_WIDTH-1:0]  len_q;
   logic [CNT_WIDTH-1:0]        edge_cnt;

   logic [PARAM_LEN_WIDTH-1:0]  bit_num;
   logic [PARAM_LEN_WIDTH-1:0]  next_bit_num;
   logic [PARAM_LEN_WIDTH-1:0]  cur_idx;
   logic [PARAM_LEN_WIDTH-1:0]  next_idx;
   logic [PARAM_LEN_WIDTH-1:0]  first_idx;
   logic                        last_edge;
   logic                        accept;

   // Map the serial bit position (edge_cnt/2) onto a word index for the frozen
   // bit order; the same index places outgoing and incoming bits.
   always_comb begin
      bit_num      = edge_cnt[CNT_WIDTH-1:1];
      next_bit_num = bit_num + PARAM_LEN_WIDTH'(1);
      cur_idx      = lsb_q ? bit_num : (len_q - bit_num);
      next_idx     = lsb_q ? next_bit_num : (len_q - next_bit_num);
      first_idx    = spis_lsb_first_i ? '0 : spis_len_i;
      last_edge    = (edge_cnt == {len_q, 1'b1});
      accept       = spis_enable_i && spis_tx_valid_i && spis_tx_ready_o;
   end

   // Frame sequencer: handshake, CS setup, 2N SCK half-periods, CS hold, with
   // enable-driven abort taking priority over any strobe.
   always_ff @(posedge spis_clk) begin
      if (!spis_rst_n) begin
         state           <= IDLE;
         tx_word         <= '0;
         rx_word         <= '0;
         cpol_q          <= 1'b0;
         cpha_q          <= 1'b0;
         lsb_q           <= 1'b0;
         len_q           <= '0;
         edge_cnt        <= '0;
         spis_tx_ready_o <= 1'b0;
         spis_rx_data_o  <= '0;
         spis_rx_valid_o <= 1'b0;
         spis_busy_o     <= 1'b0;
         spis_sck_o      <= 1'b0;
         spis_mosi_o     <= 1'b0;
         spis_cs_n_o     <= 1'b1;
      end else begin
         spis_rx_valid_o <= 1'b0;
         if ((state != IDLE) && !spis_enable_i) begin
            state           <= IDLE;
            spis_cs_n_o     <= 1'b1;
            spis_sck_o      <= cpol_q;
            spis_mosi_o     <= 1'b0;
            spis_busy_o     <= 1'b0;
            spis_tx_ready_o <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  spis_sck_o <= spis_cpol_i;
                  if (accept) begin
                     tx_word         <= spis_tx_data_i;
                     rx_word         <= '0;
                     cpol_q          <= spis_cpol_i;
                     cpha_q          <= spis_cpha_i;
                     lsb_q           <= spis_lsb_first_i;
                     len_q           <= spis_len_i;
                     edge_cnt        <= '0;
                     spis_cs_n_o     <= 1'b0;
                     spis_busy_o     <= 1'b1;
                     spis_tx_ready_o <= 1'b0;
                     if (!spis_cpha_i) begin
                        spis_mosi_o <= spis_tx_data_i[first_idx];
                     end
                     state <= SETUP;
                  end else begin
                     spis_tx_ready_o <= 1'b1;
                     spis_busy_o     <= 1'b0;
                  end
               end
               SETUP: begin
                  if (spis_time_base_i) begin
                     edge_cnt <= '0;
                     state    <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (spis_time_base_i) begin
                     spis_sck_o <= ~spis_sck_o;
                     edge_cnt   <= edge_cnt + CNT_WIDTH'(1);
                     if (!edge_cnt[0]) begin
                        if (!cpha_q) begin
                           rx_word[cur_idx] <= spis_miso_i;
                        end else begin
                           spis_mosi_o <= tx_word[cur_idx];
                        end
                     end else begin
                        if (cpha_q) begin
                           rx_word[cur_idx] <= spis_miso_i;
                        end else if (!last_edge) begin
                           spis_mosi_o <= tx_word[next_idx];
                        end
                     end
                     if (last_edge) begin
                        state <= HOLD;
                     end
                  end
               end
               HOLD: begin
                  if (spis_time_base_i) begin
                     spis_cs_n_o     <= 1'b1;
                     spis_mosi_o     <= 1'b0;
                     spis_rx_data_o  <= rx_word;
                     spis_rx_valid_o <= 1'b1;
                     spis_busy_o     <= 1'b0;
                     spis_tx_ready_o <= 1'b1;
                     state           <= IDLE;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_i2s_ipi_spi_shifter.sv
// tb_spi_i2s_ipi_spi_shifter
// Directed bench for the SPI shift engine: a strobe-counting reference model
// checked every cycle, a bus monitor acting as SPI slave, and literal checks
// on frame results, strobe costs, abort and back-to-back behaviour.
module tb_spi_i2s_ipi_spi_shifter;

   localparam int W  = 32;
   localparam int LW = 5;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic          time_base;
   logic          cpol;
   logic          cpha;
   logic          lsb;
   logic [LW-1:0] len;
   logic [W-1:0]  tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [W-1:0]  rx_data;
   logic          rx_valid;
   logic          busy;
   logic          sck;
   logic          mosi;
   logic          miso;
   logic          cs_n;

   int checks   = 0;
   int failures = 0;

   // Bench-side controls shared by stimulus, model and slave.
   bit           strobe_on;
   bit           loop_mode;
   logic [W-1:0] slave_word;
   logic         slave_miso;

   // Reference model state, expressed as strobes counted since acceptance.
   bit           model_live;
   bit           m_in_frame;
   int           m_s;
   int           m_n;
   bit           m_cpol;
   bit           m_cpha;
   bit           m_lsb;
   logic [W-1:0] m_tx;
   logic [W-1:0] m_exp_rx;
   logic         e_ready;
   logic         e_busy;
   logic         e_cs_n;
   logic         e_sck;
   logic         e_mosi;
   logic         e_rx_valid;
   logic [W-1:0] e_rx_data;

   // Monitor / slave observations.
   int           cycle;
   int           strobe_cnt;
   int           frame_strobes;
   int           rx_pulses;
   int           rx_cycle;
   int           accept_cycle;
   int           rises;
   int           falls;
   bit           counting;
   logic [W-1:0] mosi_seq;
   logic [W-1:0] slave_cap;

   assign miso = loop_mode ? mosi : slave_miso;

   spi_i2s_ipi_spi_shifter #(
      .PARAM_DATA_WIDTH(W),
      .PARAM_LEN_WIDTH (LW)
   ) dut (
      .spis_clk        (clk),
      .spis_rst_n      (rst_n),
      .spis_enable_i   (en),
      .spis_time_base_i(time_base),
      .spis_cpol_i     (cpol),
      .spis_cpha_i     (cpha),
      .spis_lsb_first_i(lsb),
      .spis_len_i      (len),
      .spis_tx_data_i  (tx_data),
      .spis_tx_valid_i (tx_valid),
      .spis_tx_ready_o (tx_ready),
      .spis_rx_data_o  (rx_data),
      .spis_rx_valid_o (rx_valid),
      .spis_busy_o     (busy),
      .spis_sck_o      (sck),
      .spis_mosi_o     (mosi),
      .spis_miso_i     (miso),
      .spis_cs_n_o     (cs_n)
   );

   // 10-unit system clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Runaway guard so the bench always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value with its expectation and count the result.
   task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Bit k of the serial stream for word/length/order.
   function automatic logic frame_bit(input logic [W-1:0] word, input int n, input bit lsbf, input int k);
      logic [W-1:0] t;
      t = lsbf ? (word >> k) : (word >> (n - 1 - k));
      return t[0];
   endfunction

   // Expected MOSI after e SCK edges have been produced in the current frame.
   function automatic logic exp_mosi(input int e);
      int k;
      if (!m_cpha) begin
         k = e / 2;
         if (k > m_n - 1) k = m_n - 1;
         return frame_bit(m_tx, m_n, m_lsb, k);
      end
      if (e == 0) return 1'b0;
      return frame_bit(m_tx, m_n, m_lsb, (e - 1) / 2);
   endfunction

   // Strobe generator: one pulse every four cycles while enabled.
   initial begin
      int phase;
      phase     = 0;
      time_base = 1'b0;
      forever begin
         @(negedge clk);
         if (strobe_on) begin
            phase     = (phase + 1) % 4;
            time_base = (phase == 0);
         end else begin
            time_base = 1'b0;
         end
      end
   end

   // Reference model: a frame is 2N+2 strobes; outputs follow from the count.
   initial begin
      int e;
      model_live = 1'b0;
      m_in_frame = 1'b0;
      forever begin
         @(posedge clk);
         model_live = 1'b1;
         if (!rst_n) begin
            m_in_frame = 1'b0;
            e_ready    = 1'b0;
            e_busy     = 1'b0;
            e_cs_n     = 1'b1;
            e_sck      = 1'b0;
            e_mosi     = 1'b0;
            e_rx_valid = 1'b0;
            e_rx_data  = '0;
         end else begin
            e_rx_valid = 1'b0;
            if (!m_in_frame) begin
               e_sck = cpol;
               if (en && tx_valid && e_ready) begin
                  m_in_frame = 1'b1;
                  m_s        = 0;
                  m_n        = int'(len) + 1;
                  m_cpol     = cpol;
                  m_cpha     = cpha;
                  m_lsb      = lsb;
                  m_tx       = tx_data;
                  m_exp_rx   = (loop_mode ? tx_data : slave_word) &
                               ((m_n == W) ? {W{1'b1}} : ((W'(1) << m_n) - W'(1)));
                  e_cs_n     = 1'b0;
                  e_busy     = 1'b1;
                  e_ready    = 1'b0;
                  e_mosi     = m_cpha ? 1'b0 : frame_bit(m_tx, m_n, m_lsb, 0);
               end else begin
                  e_ready = 1'b1;
                  e_busy  = 1'b0;
               end
            end else if (!en) begin
               m_in_frame = 1'b0;
               e_cs_n     = 1'b1;
               e_sck      = m_cpol;
               e_mosi     = 1'b0;
               e_busy     = 1'b0;
               e_ready    = 1'b1;
            end else if (time_base) begin
               m_s++;
               if (m_s == 2 * m_n + 2) begin
                  m_in_frame = 1'b0;
                  e_cs_n     = 1'b1;
                  e_mosi     = 1'b0;
                  e_rx_valid = 1'b1;
                  e_rx_data  = m_exp_rx;
                  e_busy     = 1'b0;
                  e_ready    = 1'b1;
               end else begin
                  e      = m_s - 1;
                  e_sck  = m_cpol ^ (e % 2 == 1);
                  e_mosi = exp_mosi(e);
               end
            end
         end
      end
   end

   // Per-cycle comparison of every DUT output with the model.
   initial begin
      forever begin
         @(negedge clk);
         if (model_live) begin
            checkOutput("cs_n", cs_n, e_cs_n);
            checkOutput("sck", sck, e_sck);
            checkOutput("mosi", mosi, e_mosi);
            checkOutput("busy", busy, e_busy);
            checkOutput("tx_ready", tx_ready, e_ready);
            checkOutput("rx_valid", rx_valid, e_rx_valid);
            checkOutput("rx_data", rx_data, e_rx_data);
         end
      end
   end

   // Bus monitor and SPI slave: counts strobes per frame, captures MOSI on
   // rising SCK and presents the next slave bit after each falling SCK.
   initial begin
      bit prev_busy;
      bit prev_sck;
      prev_busy     = 1'b0;
      prev_sck      = 1'b0;
      counting      = 1'b0;
      cycle         = 0;
      strobe_cnt    = 0;
      frame_strobes = -1;
      rx_pulses     = 0;
      rx_cycle      = 0;
      accept_cycle  = 0;
      rises         = 0;
      falls         = 0;
      mosi_seq      = '0;
      slave_cap     = '0;
      slave_miso    = 1'b0;
      forever begin
         @(posedge clk);
         cycle++;
         #1;
         if (!rst_n) begin
            prev_busy = 1'b0;
            prev_sck  = 1'b0;
            counting  = 1'b0;
         end else begin
            if (busy && !prev_busy) begin
               counting     = 1'b1;
               strobe_cnt   = 0;
               rises        = 0;
               falls        = 0;
               mosi_seq     = '0;
               slave_cap    = '0;
               accept_cycle = cycle;
            end else if (counting && time_base) begin
               strobe_cnt++;
            end
            if (rx_valid) begin
               frame_strobes = strobe_cnt;
               counting      = 1'b0;
               rx_pulses++;
               rx_cycle      = cycle;
            end
            if (!busy && prev_busy && !rx_valid) begin
               counting = 1'b0;
            end
            if (!cs_n && sck && !prev_sck) begin
               slave_cap = slave_cap | (W'(mosi) << rises);
               mosi_seq  = {mosi_seq[W-2:0], mosi};
               rises++;
            end
            if (!cs_n && !sck && prev_sck) begin
               slave_miso = slave_word[falls];
               falls++;
            end
            prev_busy = busy;
            prev_sck  = sck;
         end
      end
   end

   // Set up a frame's configuration, raise tx_valid and wait for acceptance.
   task automatic applyStimulus(input logic c_pol, input logic c_pha, input logic c_lsb,
                                input logic [LW-1:0] c_len, input logic [W-1:0] c_data,
                                input bit c_loop, input logic [W-1:0] c_slave, input bit hold_valid);
      int guard;
      @(negedge clk);
      cpol       = c_pol;
      cpha       = c_pha;
      lsb        = c_lsb;
      len        = c_len;
      tx_data    = c_data;
      loop_mode  = c_loop;
      slave_word = c_slave;
      repeat (2) @(negedge clk);
      tx_valid = 1'b1;
      guard    = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!busy && guard < 20);
      checkOutput("accept", busy, 1'b1);
      if (!hold_valid) tx_valid = 1'b0;
   endtask

   // Wait (bounded) for the next rx_valid pulse.
   task automatic waitFrame(input string name);
      int start;
      int guard;
      start = rx_pulses;
      guard = 0;
      while (rx_pulses == start && guard < 1500) begin
         @(negedge clk);
         guard++;
      end
      checkOutput(name, (rx_pulses != start), 1'b1);
   endtask

   // Wait (bounded) until the current frame has seen a given strobe count.
   task automatic waitStrobes(input int target);
      int guard;
      guard = 0;
      while (strobe_cnt < target && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("strobe_wait", (strobe_cnt == target), 1'b1);
   endtask

   // Directed test sequence.
   initial begin
      int pulses_before;
      rst_n      = 1'b0;
      en         = 1'b0;
      cpol       = 1'b1;
      cpha       = 1'b0;
      lsb        = 1'b0;
      len        = '0;
      tx_data    = '0;
      tx_valid   = 1'b0;
      strobe_on  = 1'b0;
      loop_mode  = 1'b1;
      slave_word = '0;

      // Reset held for two cycles, then released with enable high.
      repeat (2) @(negedge clk);
      checkOutput("rst_tx_ready", tx_ready, 1'b0);
      checkOutput("rst_sck", sck, 1'b0);
      checkOutput("rst_cs_n", cs_n, 1'b1);
      rst_n = 1'b1;
      en    = 1'b1;
      @(negedge clk);
      checkOutput("idle_cs_n", cs_n, 1'b1);
      checkOutput("idle_sck", sck, 1'b1);
      checkOutput("idle_mosi", mosi, 1'b0);
      checkOutput("idle_busy", busy, 1'b0);
      checkOutput("idle_tx_ready", tx_ready, 1'b1);
      strobe_on = 1'b1;

      // Mode 0, 8-bit MSB-first loopback.
      pulses_before = rx_pulses;
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd7, 32'h0000_00A5, 1'b1, 32'h0, 1'b0);
      waitFrame("m0_done");
      checkOutput("m0_rx", rx_data, 32'h0000_00A5);
      checkOutput("m0_strobes", frame_strobes, 18);
      checkOutput("m0_rises", rises, 8);
      checkOutput("m0_mosi_seq", mosi_seq, 32'h0000_00A5);
      repeat (3) @(negedge clk);
      checkOutput("m0_pulses", rx_pulses - pulses_before, 1);

      // Mode 3, 16-bit LSB-first against a slave returning 0xBEEF.
      applyStimulus(1'b1, 1'b1, 1'b1, 5'd15, 32'h0000_1234, 1'b0, 32'h0000_BEEF, 1'b0);
      waitFrame("m3_done");
      checkOutput("m3_rx", rx_data, 32'h0000_BEEF);
      checkOutput("m3_slave_cap", slave_cap, 32'h0000_1234);
      checkOutput("m3_mosi_seq", mosi_seq, 32'h0000_2C48);
      checkOutput("m3_strobes", frame_strobes, 34);
      @(negedge clk);
      checkOutput("m3_sck_idle", sck, 1'b1);

      // Shortest frame: one bit.
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0003, 1'b1, 32'h0, 1'b0);
      waitFrame("n1_done");
      checkOutput("n1_rx", rx_data, 32'h0000_0001);
      checkOutput("n1_strobes", frame_strobes, 4);
      checkOutput("n1_rises", rises, 1);

      // Longest frame: 32 bits.
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd31, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
      waitFrame("n32_done");
      checkOutput("n32_rx", rx_data, 32'hDEAD_BEEF);
      checkOutput("n32_strobes", frame_strobes, 66);

      // Abort after the fifth strobe, then a fresh frame once re-enabled.
      pulses_before = rx_pulses;
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd7, 32'h0000_003C, 1'b1, 32'h0, 1'b0);
      waitStrobes(5);
      en = 1'b0;
      @(negedge clk);
      checkOutput("abort_cs_n", cs_n, 1'b1);
      checkOutput("abort_busy", busy, 1'b0);
      checkOutput("abort_sck", sck, 1'b0);
      checkOutput("abort_rx_valid", rx_valid, 1'b0);
      checkOutput("abort_rx_keep", rx_data, 32'hDEAD_BEEF);
      en = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("abort_no_pulse", rx_pulses - pulses_before, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd7, 32'h0000_0096, 1'b1, 32'h0, 1'b0);
      waitFrame("post_abort_done");
      checkOutput("post_abort_rx", rx_data, 32'h0000_0096);

      // Back-to-back with tx_valid held and a 50-cycle strobe stall mid-SHIFT.
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd7, 32'h0000_005A, 1'b1, 32'h0, 1'b1);
      tx_data = 32'h0000_00C3;
      waitStrobes(7);
      strobe_on = 1'b0;
      repeat (50) @(negedge clk);
      checkOutput("stall_tx_ready", tx_ready, 1'b0);
      checkOutput("stall_busy", busy, 1'b1);
      checkOutput("stall_cs_n", cs_n, 1'b0);
      strobe_on = 1'b1;
      waitFrame("b2b_first_done");
      checkOutput("b2b_first_rx", rx_data, 32'h0000_005A);
      checkOutput("b2b_ready_on_hold", tx_ready, 1'b1);
      @(negedge clk);
      checkOutput("b2b_second_busy", busy, 1'b1);
      checkOutput("b2b_accept_gap", accept_cycle - rx_cycle, 1);
      tx_valid = 1'b0;
      waitFrame("b2b_second_done");
      checkOutput("b2b_second_rx", rx_data, 32'h0000_00C3);
      checkOutput("b2b_second_strobes", frame_strobes, 18);

      strobe_on = 1'b0;
      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
